// File: rtl/lc3_control_fsm.sv
// LC-3 instruction-sequencing Moore FSM: fetch/decode/execute, datapath controls and active-low memory strobes.
// Optional single-step mode: define LC3_SINGLE_STEP_EN.
module lc3_control_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] State_dbg
);

  typedef enum logic [4:0] {
    HALTED = 5'd0,  S18 = 5'd1,  S33 = 5'd2,  S35 = 5'd3,  S32 = 5'd4,
    S01    = 5'd5,  S05 = 5'd6,  S09 = 5'd7,  S00 = 5'd8,  S22 = 5'd9,
    S12    = 5'd10, S04 = 5'd11, S21 = 5'd12, S20 = 5'd13, S06 = 5'd14,
    S25    = 5'd15, S27 = 5'd16, S07 = 5'd17, S23 = 5'd18, S16 = 5'd19,
    P1     = 5'd20, P2  = 5'd21
`ifdef LC3_SINGLE_STEP_EN
    , STEP = 5'd22, STEP2 = 5'd23
`endif
  } state_t;

  // Where every completed (or skipped) instruction goes next.
`ifdef LC3_SINGLE_STEP_EN
  localparam state_t RET = STEP;
`else
  localparam state_t RET = S18;
`endif

  state_t     state, next_state;
  logic [2:0] wait_cnt;
  logic       mem_state, wait_done;

  assign State_dbg = state;

  always_comb begin
    mem_state = (state == S33) || (state == S25) || (state == S16);
    wait_done = (wait_cnt == 3'(MEM_WAIT - 1));
  end

  // Memory states never follow each other, so the counter is zero on every entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= HALTED;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= (mem_state && !wait_done) ? wait_cnt + 3'd1 : '0;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      HALTED: if (Run) next_state = S18;
      S18:    next_state = S33;
      S33:    if (wait_done) next_state = S35;
      S35:    next_state = S32;
      S32: begin
        unique case (Opcode)
          4'b0001: next_state = S01;
          4'b0101: next_state = S05;
          4'b1001: next_state = S09;
          4'b0000: next_state = S00;
          4'b1100: next_state = S12;
          4'b0100: next_state = S04;
          4'b0110: next_state = S06;
          4'b0111: next_state = S07;
          4'b1101: next_state = P1;
          default: next_state = RET;
        endcase
      end
      S01, S05, S09, S22, S12, S21, S20, S27: next_state = RET;
      S00:    next_state = BEN ? S22 : RET;
      S04:    next_state = IR_11 ? S21 : S20;
      S06:    next_state = S25;
      S25:    if (wait_done) next_state = S27;
      S07:    next_state = S23;
      S23:    next_state = S16;
      S16:    if (wait_done) next_state = RET;
      P1:     if (Continue) next_state = P2;
      P2:     if (!Continue) next_state = RET;
`ifdef LC3_SINGLE_STEP_EN
      STEP:   if (Continue) next_state = STEP2;
      STEP2:  if (!Continue) next_state = S18;
`endif
      default: next_state = HALTED;
    endcase
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; MIO_EN = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00;
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    unique case (state)
      S18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
      S33, S25: begin Mem_CE = 1'b0; Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = 1'b1; end
      S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S32: LD_BEN = 1'b1;
      S01, S05: begin
        SR1MUX = 1'b1; SR2MUX = IR_5; ALUK = (state == S05) ? 2'b01 : 2'b00;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S09: begin SR1MUX = 1'b1; ALUK = 2'b10; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S22, S21: begin
        ADDR2MUX = (state == S22) ? 2'b10 : 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S12, S20: begin SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
      S04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S06, S07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S23: begin ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
      S16: begin Mem_CE = 1'b0; Mem_WE = 1'b0; end
      P1:  LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench for lc3_control_fsm: driver queues expected per-cycle state/outputs, monitor checks at negedge.
module tb_lc3_control_fsm;
  localparam int unsigned MW = 3;

  localparam logic [4:0] HALTED = 5'd0, S18 = 5'd1, S33 = 5'd2, S35 = 5'd3, S32 = 5'd4,
    S01 = 5'd5, S05 = 5'd6, S09 = 5'd7, S00 = 5'd8, S22 = 5'd9, S12 = 5'd10, S04 = 5'd11,
    S21 = 5'd12, S20 = 5'd13, S06 = 5'd14, S25 = 5'd15, S27 = 5'd16, S07 = 5'd17,
    S23 = 5'd18, S16 = 5'd19, P1 = 5'd20, P2 = 5'd21, STEP = 5'd22, STEP2 = 5'd23;

  logic Clk = 1'b0;
  logic Reset_n, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic Mem_CE, Mem_OE, Mem_WE;
  logic [4:0] State_dbg;

  typedef struct packed {
    logic [4:0] st;
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux, mio_en;
    logic [1:0] addr2mux, aluk;
    logic ce, oe, we;
  } obs_t;

  obs_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  lc3_control_fsm #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MIO_EN(MIO_EN), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .State_dbg(State_dbg)
  );

  always #5 Clk = ~Clk;

  // Expected outputs for each state, written straight from the state table.
  function automatic obs_t exp_of(input logic [4:0] s, input logic ir5);
    obs_t e;
    e = '0; e.st = s; e.ce = 1'b1; e.oe = 1'b1; e.we = 1'b1;
    case (s)
      S18: begin e.g_pc = 1; e.ld_mar = 1; e.ld_pc = 1; end
      S33, S25: begin e.ce = 0; e.oe = 0; e.mio_en = 1; e.ld_mdr = 1; end
      S35: begin e.g_mdr = 1; e.ld_ir = 1; end
      S32: e.ld_ben = 1;
      S01: begin e.sr1mux = 1; e.sr2mux = ir5; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      S05: begin e.sr1mux = 1; e.sr2mux = ir5; e.aluk = 2'b01; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      S09: begin e.sr1mux = 1; e.aluk = 2'b10; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      S22: begin e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1; end
      S12, S20: begin e.sr1mux = 1; e.addr1mux = 1; e.pcmux = 2'b10; e.ld_pc = 1; end
      S04: begin e.g_pc = 1; e.drmux = 1; e.ld_reg = 1; end
      S21: begin e.addr2mux = 2'b11; e.pcmux = 2'b10; e.ld_pc = 1; end
      S06, S07: begin e.sr1mux = 1; e.addr1mux = 1; e.addr2mux = 2'b01; e.g_marmux = 1; e.ld_mar = 1; end
      S27: begin e.g_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; end
      S23: begin e.aluk = 2'b11; e.g_alu = 1; e.ld_mdr = 1; end
      S16: begin e.ce = 0; e.we = 0; end
      P1:  e.ld_led = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick(input logic [4:0] s);
    @(posedge Clk); #1;
    sb.push_back(exp_of(s, IR_5));
  endtask

  task automatic ret();
`ifdef LC3_SINGLE_STEP_EN
    tick(STEP); tick(STEP);
    Continue = 1'b1; tick(STEP2);
    Continue = 1'b0; tick(S18);
`else
    tick(S18);
`endif
  endtask

  task automatic fetch(input logic [3:0] op);
    Opcode = op;
    repeat (MW) tick(S33);
    tick(S35);
    tick(S32);
  endtask

  always @(negedge Clk) begin
    obs_t a, e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{State_dbg, LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
            GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
            MIO_EN, ADDR2MUX, ALUK, Mem_CE, Mem_OE, Mem_WE};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_state%0d @%0t: got %h required %h", e.st, $time, a, e);
      end
    end
  end

  initial begin
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    tick(HALTED); tick(HALTED);
    Reset_n = 1'b1; tick(HALTED);
    Run = 1'b1; tick(S18);
    Run = 1'b0;
    // ADD R1,R1,#1 (0x1261)
    IR_5 = 1'b1; fetch(4'b0001); tick(S01); ret();
    IR_5 = 1'b0; fetch(4'b0101); tick(S05); ret();
    Run = 1'b1; fetch(4'b1001); tick(S09); ret(); Run = 1'b0;
    // BR 0x0E02 not taken, then taken
    BEN = 1'b0; fetch(4'b0000); tick(S00); ret();
    BEN = 1'b1; fetch(4'b0000); tick(S00); tick(S22); ret();
    BEN = 1'b0;
    fetch(4'b1100); tick(S12); ret();
    IR_11 = 1'b1; fetch(4'b0100); tick(S04); tick(S21); ret();
    IR_11 = 1'b0; fetch(4'b0100); tick(S04); tick(S20); ret();
    fetch(4'b0110); tick(S06); repeat (MW) tick(S25); tick(S27); ret();
    // STR 0x7042
    fetch(4'b0111); tick(S07); tick(S23); repeat (MW) tick(S16); ret();
    // PAUSE with Continue already held
    Continue = 1'b1; fetch(4'b1101); tick(P1); tick(P2); tick(P2);
    Continue = 1'b0; ret();
    fetch(4'b1101); tick(P1); tick(P1); tick(P1);
    Continue = 1'b1; tick(P2);
    Continue = 1'b0; ret();
    fetch(4'b1111); ret();
    // Reset in the middle of a write
    fetch(4'b0111); tick(S07); tick(S23); tick(S16); tick(S16);
    @(negedge Clk); #1;
    Reset_n = 1'b0; tick(HALTED);
    Reset_n = 1'b1; tick(HALTED);
    Run = 1'b1; tick(S18);
    Run = 1'b0; tick(S33);
    repeat (3) @(posedge Clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
